// File: rtl/alu_scheduler_if.sv
// Bus bundle for alu_scheduler: requester handshakes, tagged response channel and
// the operand/opcode/result wires of the shared combinational ALU.
interface alu_scheduler_if #(
  parameter int DataSize  = 32,
  parameter int ALUopSize = 4,
  parameter int NUM_REQ   = 4,
  parameter int IdSize    = 2
);
  // Valid/ready: a transfer happens on a rising clk edge where both valid and ready
  // are high; the sender holds valid and its payload stable until that edge.
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*DataSize-1:0]  req_src1;
  logic [NUM_REQ*DataSize-1:0]  req_src2;
  logic [NUM_REQ*ALUopSize-1:0] req_type;
  logic                         resp_valid;
  logic                         resp_ready;
  logic [IdSize-1:0]            resp_id;
  logic [DataSize-1:0]          resp_result;
  logic                         resp_zero;
  logic                         resp_err;
  logic [DataSize-1:0]          alu_src1;
  logic [DataSize-1:0]          alu_src2;
  logic [ALUopSize-1:0]         alu_type;
  logic                         alu_rst;
  logic [DataSize-1:0]          alu_result;
  logic                         alu_zero;

  modport slave (
    input  req_valid, req_src1, req_src2, req_type, resp_ready, alu_result, alu_zero,
    output req_ready, resp_valid, resp_id, resp_result, resp_zero, resp_err,
           alu_src1, alu_src2, alu_type, alu_rst
  );

  modport master (
    output req_valid, req_src1, req_src2, req_type, resp_ready, alu_result, alu_zero,
    input  req_ready, resp_valid, resp_id, resp_result, resp_zero, resp_err,
           alu_src1, alu_src2, alu_type, alu_rst
  );
endinterface

// File: rtl/alu_scheduler.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters;
// one operation in flight, result registered and returned tagged with its requester ID.
module alu_scheduler #(
  parameter int DataSize  = 32,
  parameter int ALUopSize = 4,
  parameter int NUM_REQ   = 4,
  parameter int IdSize    = 2
) (
  input  logic           clk,
  input  logic           rst,
  alu_scheduler_if.slave bus,
  output logic [1:0]     dbg_state_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam int CW = IdSize + 1;

  logic [1:0]           state_q, state_d;
  logic [IdSize-1:0]    rr_ptr_q, rr_ptr_d;
  logic [DataSize-1:0]  op_src1_q, op_src1_d;
  logic [DataSize-1:0]  op_src2_q, op_src2_d;
  logic [ALUopSize-1:0] op_type_q, op_type_d;
  logic [IdSize-1:0]    op_id_q, op_id_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [IdSize-1:0]    resp_id_q, resp_id_d;
  logic [DataSize-1:0]  resp_result_q, resp_result_d;
  logic                 resp_zero_q, resp_zero_d;
  logic                 resp_err_q, resp_err_d;

  logic                 grant_found;
  logic [IdSize-1:0]    grant_idx;
  logic [CW-1:0]        cand;
  logic [CW-1:0]        rr_next;
  logic                 do_grant;

  // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + CW'(k);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!grant_found && bus.req_valid[cand[IdSize-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IdSize-1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    op_src1_d     = op_src1_q;
    op_src2_d     = op_src2_q;
    op_type_d     = op_type_q;
    op_id_d       = op_id_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_zero_d   = resp_zero_q;
    resp_err_d    = resp_err_q;
    do_grant      = 1'b0;
    rr_next       = {1'b0, grant_idx} + CW'(1);
    if (rr_next == CW'(NUM_REQ)) rr_next = '0;

    case (state_q)
      IDLE: do_grant = grant_found;
      EXEC: begin
        resp_result_d = bus.alu_result;
        resp_zero_d   = (op_type_q == ALUopSize'(4)) ? bus.alu_zero : 1'b0;
        resp_err_d    = (op_type_q >= ALUopSize'(8));
        resp_id_d     = op_id_q;
        resp_valid_d  = 1'b1;
        state_d       = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
          do_grant     = grant_found;
        end
      end
      default: state_d = IDLE;
    endcase

    // A grant from IDLE or from a completing RESP both launch straight into EXEC.
    if (do_grant) begin
      op_src1_d = bus.req_src1[int'(grant_idx) * DataSize +: DataSize];
      op_src2_d = bus.req_src2[int'(grant_idx) * DataSize +: DataSize];
      op_type_d = bus.req_type[int'(grant_idx) * ALUopSize +: ALUopSize];
      op_id_d   = grant_idx;
      rr_ptr_d  = rr_next[IdSize-1:0];
      state_d   = EXEC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      op_src1_q     <= '0;
      op_src2_q     <= '0;
      op_type_q     <= '0;
      op_id_q       <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_result_q <= '0;
      resp_zero_q   <= 1'b0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      op_src1_q     <= op_src1_d;
      op_src2_q     <= op_src2_d;
      op_type_q     <= op_type_d;
      op_id_q       <= op_id_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_zero_q   <= resp_zero_d;
      resp_err_q    <= resp_err_d;
    end
  end

  assign bus.req_ready   = (do_grant && !rst) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_result = resp_result_q;
  assign bus.resp_zero   = resp_zero_q;
  assign bus.resp_err    = resp_err_q;
  // Op regs keep driving the ALU outside EXEC; alu_rst marks those cycles as don't-care.
  assign bus.alu_src1    = op_src1_q;
  assign bus.alu_src2    = op_src2_q;
  assign bus.alu_type    = op_type_q;
  assign bus.alu_rst     = rst || (state_q != EXEC);
  assign dbg_state_o     = state_q;
endmodule
